// File: rtl/pc_unit.sv
// Fetch program counter with MIPS delay-slot branch parking across IF stalls.
// Ports: clk/rst, IF_PCWr, Branch_*, Exc_Req, Eret_Req/EPC -> IF_PC, IF_NPC, IF_AddrErr, IF_BrPending.
module pc_unit #(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 32'hBFC0_0000,
  parameter logic [PC_WIDTH-1:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int                  FETCH_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IF_PCWr,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] Branch_Target,
  input  logic                Exc_Req,
  input  logic                Eret_Req,
  input  logic [PC_WIDTH-1:0] EPC,
  output logic [PC_WIDTH-1:0] IF_PC,
  output logic [PC_WIDTH-1:0] IF_NPC,
  output logic                IF_AddrErr,
  output logic                IF_BrPending
);

  typedef enum logic {
    RUN     = 1'b0,
    BR_PEND = 1'b1
  } state_e;

  localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(FETCH_BYTES);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_q, pend_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    if (Exc_Req) begin
      pc_d    = EXC_VECTOR;
      state_d = RUN;
    end else if (Eret_Req) begin
      pc_d    = EPC;
      state_d = RUN;
    end else if (state_q == BR_PEND) begin
      // A second branch here would sit in a delay slot: ignore it.
      if (IF_PCWr) begin
        pc_d    = pend_q;
        state_d = RUN;
      end
    end else if (Branch_Taken) begin
      if (IF_PCWr) begin
        pc_d = Branch_Target;
      end else begin
        // Delay slot not yet fetched: park the target until IF advances.
        pend_d  = Branch_Target;
        state_d = BR_PEND;
      end
    end else if (IF_PCWr) begin
      pc_d = pc_q + INC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign IF_PC        = pc_q;
  assign IF_NPC       = pc_d;
  assign IF_AddrErr   = (pc_q[1:0] != 2'b00);
  assign IF_BrPending = (state_q == BR_PEND);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed steps plus random traffic
// against a transaction-level model, with FETCH_BYTES 4 and 8 instances.
module tb_pc_unit;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic        bt;
  logic [31:0] tgt;
  logic        exc;
  logic        eret;
  logic [31:0] epc;

  logic [31:0] pc4, npc4, pc8, npc8;
  logic        ae4, ae8, bp4, bp8;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc4, m_pc8;
  logic [31:0] parked[$];

  always #5 clk = ~clk;

  pc_unit #(.FETCH_BYTES(4)) dut4 (
    .clk(clk), .rst(rst), .IF_PCWr(wr),
    .Branch_Taken(bt), .Branch_Target(tgt),
    .Exc_Req(exc), .Eret_Req(eret), .EPC(epc),
    .IF_PC(pc4), .IF_NPC(npc4),
    .IF_AddrErr(ae4), .IF_BrPending(bp4)
  );

  pc_unit #(.FETCH_BYTES(8)) dut8 (
    .clk(clk), .rst(rst), .IF_PCWr(wr),
    .Branch_Taken(bt), .Branch_Target(tgt),
    .Exc_Req(exc), .Eret_Req(eret), .EPC(epc),
    .IF_PC(pc8), .IF_NPC(npc8),
    .IF_AddrErr(ae8), .IF_BrPending(bp8)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next fetch address for the current inputs.
  function automatic logic [31:0] model_next(input logic [31:0] pc,
                                             input int fb);
    if (exc)                 return EXC_PC;
    if (eret)                return epc;
    if (parked.size() != 0)  return wr ? parked[0] : pc;
    if (bt)                  return wr ? tgt : pc;
    if (wr)                  return pc + 32'(fb);
    return pc;
  endfunction

  task automatic step(input logic r, input logic w, input logic b,
                      input logic [31:0] t, input logic e,
                      input logic er, input logic [31:0] ep,
                      input string tag);
    logic [31:0] e4, e8;
    rst = r; wr = w; bt = b; tgt = t;
    exc = e; eret = er; epc = ep;
    #1;
    e4 = model_next(m_pc4, 4);
    e8 = model_next(m_pc8, 8);
    if (r) begin
      check({tag, ".npc4"}, npc4, e4);
      check({tag, ".npc8"}, npc8, e8);
    end
    @(posedge clk);
    if (!r) begin
      m_pc4 = RST_PC;
      m_pc8 = RST_PC;
      parked.delete();
    end else begin
      m_pc4 = e4;
      m_pc8 = e8;
      if (e || er)
        parked.delete();
      else if (parked.size() != 0 && w)
        parked.delete();
      else if (parked.size() == 0 && b && !w)
        parked.push_back(t);
    end
    #1;
    check({tag, ".pc4"}, pc4, m_pc4);
    check({tag, ".pc8"}, pc8, m_pc8);
    check({tag, ".bp4"}, 32'(bp4), 32'(parked.size() != 0));
    check({tag, ".bp8"}, 32'(bp8), 32'(parked.size() != 0));
    check({tag, ".ae4"}, 32'(ae4), 32'(m_pc4[1:0] != 2'b00));
    check({tag, ".ae8"}, 32'(ae8), 32'(m_pc8[1:0] != 2'b00));
  endtask

  initial begin
    m_pc4 = '0;
    m_pc8 = '0;
    rst = 1'b0; wr = 1'b1; bt = 1'b0; tgt = '0;
    exc = 1'b1; eret = 1'b0; epc = '0;

    step(0, 1, 0, 0, 1, 0, 0, "reset");
    check("reset_pc", pc4, 32'hBFC0_0000);
    step(1, 1, 0, 0, 0, 0, 0, "seq1");
    step(1, 1, 0, 0, 0, 0, 0, "seq2");
    check("seq_pc", pc4, 32'hBFC0_0008);

    step(1, 1, 1, 32'h8000_1000, 0, 0, 0, "br_go");
    check("br_go_pc", pc4, 32'h8000_1000);

    step(1, 0, 1, 32'h8000_2000, 0, 0, 0, "br_stall");
    step(1, 0, 1, 32'hDEAD_0000, 0, 0, 0, "stall2");
    step(1, 0, 0, 0, 0, 0, 0, "stall3");
    step(1, 0, 0, 0, 0, 0, 0, "stall4");
    check("stall_bp", 32'(bp4), 32'd1);
    step(1, 1, 0, 0, 0, 0, 0, "release");
    check("release_pc", pc4, 32'h8000_2000);

    step(1, 0, 1, 32'h8000_3000, 0, 0, 0, "park2");
    step(1, 0, 0, 0, 1, 1, 32'h1234_5678, "exc_eret");
    check("exc_pc", pc4, 32'hBFC0_0380);
    step(1, 1, 0, 0, 0, 0, 0, "after_exc");
    check("no_parked", pc4, 32'hBFC0_0384);

    step(1, 0, 0, 0, 0, 1, 32'h8000_0002, "eret_odd");
    check("addrerr", 32'(ae4), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0, "rst_again");
    check("rst_again_pc", pc4, 32'hBFC0_0000);

    step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, "eret_fc");
    step(1, 1, 0, 0, 0, 0, 0, "wrap4");
    check("wrap4_pc", pc4, 32'h0000_0000);
    step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFF8, "eret_f8");
    step(1, 1, 0, 0, 0, 0, 0, "wrap8");
    check("wrap8_pc", pc8, 32'h0000_0000);

    for (int i = 0; i < 300; i++) begin
      logic        r_r, r_w, r_b, r_e, r_er;
      logic [31:0] r_t, r_ep;
      r_r  = ($urandom_range(0, 39) != 0);
      r_w  = ($urandom_range(0, 2) != 0);
      r_b  = ($urandom_range(0, 3) == 0);
      r_e  = ($urandom_range(0, 19) == 0);
      r_er = ($urandom_range(0, 14) == 0);
      r_t  = $urandom & 32'hFFFF_FFFC;
      r_ep = $urandom;
      if ($urandom_range(0, 3) == 0) r_ep[1:0] = 2'b00;
      step(r_r, r_w, r_b, r_t, r_e, r_er, r_ep, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
